// File: rtl/tdpram_pkg.sv
// tdpram_pkg: shared state encoding and byte-lane merge helper for the dual-port RAM
package tdpram_pkg;
  localparam int MAX_W = 512;
  localparam int MAX_B = MAX_W / 8;
  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_e;
  function automatic int nbytes(input int w);
    return w / 8;
  endfunction
  // Callers zero-extend into MAX_W lanes and truncate the result back to their width
  function automatic logic [MAX_W-1:0] merge_bytes(input logic [MAX_W-1:0] old_w, input logic [MAX_W-1:0] new_w, input logic [MAX_B-1:0] be);
    for (int i = 0; i < MAX_B; i++) merge_bytes[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
  endfunction
endpackage

// File: rtl/tdpram_sclk_be_if.sv
// tdpram_sclk_be_if: two-port RAM access bus plus busy/collision status
interface tdpram_sclk_be_if import tdpram_pkg::*; #(parameter int DATA_W = 8, parameter int ADDR_W = 6) ();
  localparam int NB = nbytes(DATA_W);
  logic en_a, we_a, en_b, we_b, busy, collision;
  logic [NB-1:0] be_a, be_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] data_a, data_b, q_a, q_b;
  modport master (output en_a, we_a, be_a, addr_a, data_a, en_b, we_b, be_b, addr_b, data_b,
                  input q_a, q_b, busy, collision);
  modport slave (input en_a, we_a, be_a, addr_a, data_a, en_b, we_b, be_b, addr_b, data_b,
                 output q_a, q_b, busy, collision);
endinterface

// File: rtl/tdpram_port_rd.sv
// tdpram_port_rd: one port's read path with read-during-write select, enable hold and optional output stage
module tdpram_port_rd import tdpram_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              busy,
  input  logic              en,
  input  logic              we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] rd_d, rd_q, out_d, out_q, mrg;
  logic vld_d, vld_q;
  always_comb begin
    mrg = DATA_W'(merge_bytes(MAX_W'(old_word), MAX_W'(wdata), MAX_B'(be)));
    rd_d = busy ? '0 : en ? ((RDW_MODE != 0 && we) ? mrg : old_word) : rd_q;
    vld_d = en & ~busy;
    // output stage only advances on a read captured the cycle before
    out_d = busy ? '0 : vld_q ? rd_q : out_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      out_q <= out_d;
      vld_q <= vld_d;
    end
  assign q = (OUT_REG != 0) ? out_q : rd_q;
endmodule

// File: rtl/tdpram_sclk_be.sv
// tdpram_sclk_be: single-clock true dual-port RAM with byte enables, post-reset zero-fill and collision flag
module tdpram_sclk_be import tdpram_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input logic clk,
  input logic rst_n,
  tdpram_sclk_be_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam state_e ST_RST = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
  logic [DATA_W-1:0] mem [DEPTH];
  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic col_q, col_d, busy, wr_a, wr_b, same_wr;
  logic [DATA_W-1:0] wa_word, wb_word;
  always_comb begin
    busy = state_q == ST_CLEAR;
    wr_a = bus.en_a & bus.we_a & ~busy;
    wr_b = bus.en_b & bus.we_b & ~busy;
    same_wr = wr_a & wr_b & (bus.addr_a == bus.addr_b);
    wb_word = DATA_W'(merge_bytes(MAX_W'(mem[bus.addr_b]), MAX_W'(bus.data_b), MAX_B'(bus.be_b)));
    // on a shared address A's lanes are layered over B's merged word
    wa_word = DATA_W'(merge_bytes(same_wr ? MAX_W'(wb_word) : MAX_W'(mem[bus.addr_a]), MAX_W'(bus.data_a), MAX_B'(bus.be_a)));
    state_d = (busy && &cnt_q) ? ST_READY : state_q;
    cnt_d = busy ? cnt_q + 1'b1 : cnt_q;
    col_d = same_wr;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_RST;
      cnt_q <= '0;
      col_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      col_q <= col_d;
    end
  always_ff @(posedge clk)
    if (busy) mem[cnt_q] <= '0;
    else begin
      if (wr_b) mem[bus.addr_b] <= wb_word;
      if (wr_a) mem[bus.addr_a] <= wa_word;
    end
  tdpram_port_rd #(.DATA_W(DATA_W), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)) u_rd_a (
    .clk(clk), .rst_n(rst_n), .busy(busy), .en(bus.en_a), .we(bus.we_a), .be(bus.be_a),
    .old_word(mem[bus.addr_a]), .wdata(bus.data_a), .q(bus.q_a));
  tdpram_port_rd #(.DATA_W(DATA_W), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)) u_rd_b (
    .clk(clk), .rst_n(rst_n), .busy(busy), .en(bus.en_b), .we(bus.we_b), .be(bus.be_b),
    .old_word(mem[bus.addr_b]), .wdata(bus.data_b), .q(bus.q_b));
  assign bus.busy = busy;
  assign bus.collision = col_q;
endmodule

// File: tb/tb_tdpram_sclk_be.sv
// tb_tdpram_sclk_be: directed checks on an 8-bit read-first RAM and a 16-bit write-through, output-registered RAM
module tb_tdpram_sclk_be;
  logic clk, rst_n;
  int pass_n = 0, chk_n = 0;
  tdpram_sclk_be_if #(.DATA_W(8), .ADDR_W(6)) i0 ();
  tdpram_sclk_be_if #(.DATA_W(16), .ADDR_W(6)) i1 ();
  tdpram_sclk_be #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RST(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  tdpram_sclk_be #(.DATA_W(16), .ADDR_W(6), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RST(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i0.en_a = 0; i0.we_a = 0; i0.en_b = 0; i0.we_b = 0; i0.be_a = '1; i0.be_b = '1;
    i1.en_a = 0; i1.we_a = 0; i1.en_b = 0; i1.we_b = 0; i1.be_a = '1; i1.be_b = '1;
  endtask

  task automatic test_reset();
    int n;
    tick(2);
    chk_n++; if (i0.busy !== 1'b1) $display("FAIL rst_busy0 actual=%b expected=1", i0.busy); else pass_n++;
    chk_n++; if (i1.busy !== 1'b1) $display("FAIL rst_busy1 actual=%b expected=1", i1.busy); else pass_n++;
    chk_n++; if (i0.q_a !== 8'h00) $display("FAIL rst_q_a0 actual=%h expected=00", i0.q_a); else pass_n++;
    chk_n++; if (i1.q_b !== 16'h0000) $display("FAIL rst_q_b1 actual=%h expected=0000", i1.q_b); else pass_n++;
    chk_n++; if (i0.collision !== 1'b0) $display("FAIL rst_col0 actual=%b expected=0", i0.collision); else pass_n++;
    rst_n = 1;
    i0.en_a = 1; i0.we_a = 1; i0.addr_a = 7; i0.data_a = 8'hFF;
    i0.en_b = 1; i0.addr_b = 7;
    n = 0;
    while (i0.busy && n < 200) begin
      tick();
      n++;
      if (n == 10) begin
        chk_n++; if (i0.q_a !== 8'h00) $display("FAIL busy_q_a actual=%h expected=00", i0.q_a); else pass_n++;
      end
    end
    idle();
    chk_n++; if (n !== 64) $display("FAIL sweep_len actual=%0d expected=64", n); else pass_n++;
    chk_n++; if (i1.busy !== 1'b0) $display("FAIL sweep_done1 actual=%b expected=0", i1.busy); else pass_n++;
  endtask

  task automatic test_clear();
    int addrs[4] = '{0, 31, 63, 7};
    foreach (addrs[k]) begin
      i0.en_a = 1; i0.addr_a = 6'(addrs[k]); i0.en_b = 1; i0.addr_b = 6'(addrs[k]);
      i1.en_a = 1; i1.addr_a = 6'(addrs[k]); i1.en_b = 1; i1.addr_b = 6'(addrs[k]);
      tick();
      idle();
      chk_n++; if (i0.q_a !== 8'h00) $display("FAIL clr_q_a0 addr=%0d actual=%h expected=00", addrs[k], i0.q_a); else pass_n++;
      chk_n++; if (i0.q_b !== 8'h00) $display("FAIL clr_q_b0 addr=%0d actual=%h expected=00", addrs[k], i0.q_b); else pass_n++;
      tick();
      chk_n++; if (i1.q_a !== 16'h0000) $display("FAIL clr_q_a1 addr=%0d actual=%h expected=0000", addrs[k], i1.q_a); else pass_n++;
      chk_n++; if (i1.q_b !== 16'h0000) $display("FAIL clr_q_b1 addr=%0d actual=%h expected=0000", addrs[k], i1.q_b); else pass_n++;
    end
  endtask

  task automatic test_write_read();
    i0.en_a = 1; i0.we_a = 1; i0.addr_a = 0; i0.data_a = 8'hAA;
    i1.en_a = 1; i1.we_a = 1; i1.addr_a = 0; i1.data_a = 16'h00AA;
    tick();
    idle();
    i0.en_b = 1; i0.addr_b = 0; i1.en_b = 1; i1.addr_b = 0;
    tick();
    idle();
    chk_n++; if (i0.q_b !== 8'hAA) $display("FAIL wr_lat1 actual=%h expected=aa", i0.q_b); else pass_n++;
    chk_n++; if (i1.q_b !== 16'h0000) $display("FAIL wr_lat2_early actual=%h expected=0000", i1.q_b); else pass_n++;
    tick();
    chk_n++; if (i1.q_b !== 16'h00AA) $display("FAIL wr_lat2 actual=%h expected=00aa", i1.q_b); else pass_n++;
    chk_n++; if (i0.q_b !== 8'hAA) $display("FAIL en_hold actual=%h expected=aa", i0.q_b); else pass_n++;
  endtask

  task automatic test_byte_enable();
    i1.en_a = 1; i1.we_a = 1; i1.addr_a = 2; i1.data_a = 16'h1234; i1.be_a = 2'b11;
    i0.en_a = 1; i0.we_a = 1; i0.addr_a = 2; i0.data_a = 8'h55; i0.be_a = 1'b1;
    tick();
    i1.data_a = 16'hABCD; i1.be_a = 2'b10;
    i0.data_a = 8'h99; i0.be_a = 1'b0;
    tick();
    i1.data_a = 16'hFFFF; i1.be_a = 2'b00;
    i0.we_a = 0;
    tick();
    chk_n++; if (i0.q_a !== 8'h55) $display("FAIL be_zero8 actual=%h expected=55", i0.q_a); else pass_n++;
    idle();
    i1.en_a = 1; i1.addr_a = 2;
    tick();
    idle();
    tick();
    chk_n++; if (i1.q_a !== 16'hAB34) $display("FAIL be_merge16 actual=%h expected=ab34", i1.q_a); else pass_n++;
  endtask

  task automatic test_rdw();
    i0.en_a = 1; i0.we_a = 1; i0.addr_a = 5; i0.data_a = 8'h11;
    i1.en_a = 1; i1.we_a = 1; i1.addr_a = 5; i1.data_a = 16'h1111;
    tick();
    i0.data_a = 8'h22; i0.en_b = 1; i0.addr_b = 5;
    i1.data_a = 16'h2222; i1.be_a = 2'b01; i1.en_b = 1; i1.addr_b = 5;
    tick();
    idle();
    chk_n++; if (i0.q_a !== 8'h11) $display("FAIL rdw_old_a actual=%h expected=11", i0.q_a); else pass_n++;
    chk_n++; if (i0.q_b !== 8'h11) $display("FAIL rdw_cross_b0 actual=%h expected=11", i0.q_b); else pass_n++;
    tick();
    chk_n++; if (i1.q_a !== 16'h1122) $display("FAIL rdw_new_a actual=%h expected=1122", i1.q_a); else pass_n++;
    chk_n++; if (i1.q_b !== 16'h1111) $display("FAIL rdw_cross_b1 actual=%h expected=1111", i1.q_b); else pass_n++;
    i0.en_a = 1; i0.addr_a = 5; i1.en_b = 1; i1.addr_b = 5;
    tick();
    idle();
    chk_n++; if (i0.q_a !== 8'h22) $display("FAIL rdw_after0 actual=%h expected=22", i0.q_a); else pass_n++;
    tick();
    chk_n++; if (i1.q_b !== 16'h1122) $display("FAIL rdw_after1 actual=%h expected=1122", i1.q_b); else pass_n++;
  endtask

  task automatic test_collision();
    chk_n++; if (i0.collision !== 1'b0) $display("FAIL col_idle actual=%b expected=0", i0.collision); else pass_n++;
    i0.en_a = 1; i0.we_a = 1; i0.addr_a = 3; i0.data_a = 8'hCC;
    i0.en_b = 1; i0.we_b = 1; i0.addr_b = 3; i0.data_b = 8'hDD;
    i1.en_a = 1; i1.we_a = 1; i1.addr_a = 3; i1.data_a = 16'hFFFF; i1.be_a = 2'b00;
    i1.en_b = 1; i1.we_b = 1; i1.addr_b = 3; i1.data_b = 16'hDDEE;
    tick();
    idle();
    chk_n++; if (i0.collision !== 1'b1) $display("FAIL col_pulse0 actual=%b expected=1", i0.collision); else pass_n++;
    chk_n++; if (i1.collision !== 1'b1) $display("FAIL col_pulse1 actual=%b expected=1", i1.collision); else pass_n++;
    tick();
    chk_n++; if (i0.collision !== 1'b0) $display("FAIL col_end0 actual=%b expected=0", i0.collision); else pass_n++;
    chk_n++; if (i1.collision !== 1'b0) $display("FAIL col_end1 actual=%b expected=0", i1.collision); else pass_n++;
    i0.en_a = 1; i0.addr_a = 3; i1.en_a = 1; i1.addr_a = 3;
    tick();
    idle();
    chk_n++; if (i0.q_a !== 8'hCC) $display("FAIL col_a_wins actual=%h expected=cc", i0.q_a); else pass_n++;
    tick();
    chk_n++; if (i1.q_a !== 16'hDDEE) $display("FAIL col_b_lands actual=%h expected=ddee", i1.q_a); else pass_n++;
    i1.en_a = 1; i1.we_a = 1; i1.addr_a = 3; i1.data_a = 16'h00CC; i1.be_a = 2'b01;
    i1.en_b = 1; i1.we_b = 1; i1.addr_b = 3; i1.data_b = 16'h1122;
    tick();
    idle();
    tick();
    chk_n++; if (i1.q_a !== 16'hDDCC) $display("FAIL col_rdw_a actual=%h expected=ddcc", i1.q_a); else pass_n++;
    chk_n++; if (i1.q_b !== 16'h1122) $display("FAIL col_rdw_b actual=%h expected=1122", i1.q_b); else pass_n++;
    i1.en_b = 1; i1.addr_b = 3;
    tick();
    idle();
    tick();
    chk_n++; if (i1.q_b !== 16'h11CC) $display("FAIL col_mixed actual=%h expected=11cc", i1.q_b); else pass_n++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      i0.en_a = 1; i0.we_a = 1; i0.addr_a = 6'(10 + i); i0.data_a = 8'(8'h40 + i);
      i0.en_b = 1; i0.we_b = 1; i0.addr_b = 6'(20 + i); i0.data_b = 8'(8'h80 + i);
      tick();
    end
    idle();
    chk_n++; if (i0.collision !== 1'b0) $display("FAIL b2b_nocol actual=%b expected=0", i0.collision); else pass_n++;
    for (int i = 0; i < 4; i++) begin
      i0.en_a = 1; i0.addr_a = 6'(20 + i); i0.en_b = 1; i0.addr_b = 6'(10 + i);
      tick();
      chk_n++; if (i0.q_a !== 8'(8'h80 + i)) $display("FAIL b2b_q_a i=%0d actual=%h expected=%h", i, i0.q_a, 8'(8'h80 + i)); else pass_n++;
      chk_n++; if (i0.q_b !== 8'(8'h40 + i)) $display("FAIL b2b_q_b i=%0d actual=%h expected=%h", i, i0.q_b, 8'(8'h40 + i)); else pass_n++;
    end
    idle();
    i0.addr_b = 0;
    tick();
    chk_n++; if (i0.q_b !== 8'h43) $display("FAIL b2b_hold actual=%h expected=43", i0.q_b); else pass_n++;
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    i0.en_a = 1; i0.we_a = 1; i0.addr_a = 50; i0.data_a = 8'h5A;
    i1.en_a = 1; i1.we_a = 1; i1.addr_a = 50; i1.data_a = 16'hA5A5;
    tick();
    idle();
    i0.en_a = 1; i0.addr_a = 50;
    tick();
    idle();
    chk_n++; if (i0.q_a !== 8'h5A) $display("FAIL mid_pre actual=%h expected=5a", i0.q_a); else pass_n++;
    rst_n = 0;
    #1;
    chk_n++; if (i0.q_a !== 8'h00) $display("FAIL mid_async_q actual=%h expected=00", i0.q_a); else pass_n++;
    chk_n++; if (i0.busy !== 1'b1) $display("FAIL mid_async_busy actual=%b expected=1", i0.busy); else pass_n++;
    tick();
    rst_n = 1;
    tick(20);
    rst_n = 0;
    tick();
    rst_n = 1;
    n = 0;
    while (i1.busy && n < 200) begin
      tick();
      n++;
    end
    chk_n++; if (n !== 64) $display("FAIL mid_sweep_len actual=%0d expected=64", n); else pass_n++;
    i0.en_a = 1; i0.addr_a = 50; i0.en_b = 1; i0.addr_b = 63;
    i1.en_a = 1; i1.addr_a = 50; i1.en_b = 1; i1.addr_b = 63;
    tick();
    idle();
    chk_n++; if (i0.q_a !== 8'h00) $display("FAIL mid_clr0 actual=%h expected=00", i0.q_a); else pass_n++;
    tick();
    chk_n++; if (i1.q_a !== 16'h0000) $display("FAIL mid_clr1 actual=%h expected=0000", i1.q_a); else pass_n++;
    chk_n++; if (i1.q_b !== 16'h0000) $display("FAIL mid_clr1_63 actual=%h expected=0000", i1.q_b); else pass_n++;
  endtask

  initial begin
    rst_n = 0;
    idle();
    i0.addr_a = 0; i0.addr_b = 0; i0.data_a = 0; i0.data_b = 0;
    i1.addr_a = 0; i1.addr_b = 0; i1.data_a = 0; i1.data_b = 0;
    test_reset();
    test_clear();
    test_write_read();
    test_byte_enable();
    test_rdw();
    test_collision();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end
endmodule

// File: doc/tdpram_sclk_be.md
Name: tdpram_sclk_be

Overview:
Parametrised true dual-port RAM on a single clock. It generalises the fixed 8x64 dual-port RAM with configurable width and depth, per-port enables and byte-enables, and a selectable read-during-write mode. It adds an optional output pipeline register, same-address collision detection, and a post-reset clear sequencer that zero-fills the array. It is the standard on-chip buffer for the team's datapath blocks.

Parameters:
DATA_W, 8, data width per port in bits; must be a multiple of 8.
ADDR_W, 6, address width; DEPTH = 2**ADDR_W words.
RDW_MODE, 0, same-port read-during-write: 0 = old data (read-first), 1 = new data (write-through).
OUT_REG, 0, 1 adds an output register stage, giving read latency 2.
CLEAR_ON_RST, 1, 1 runs the zero-fill sweep after every reset release.

Ports:
clk  in  1  single clock; all logic is rising-edge.
rst_n  in  1  asynchronous active-low reset.
en_a  in  1  port A access enable.
we_a  in  1  port A write (qualified by en_a).
be_a  in  DATA_W/8  port A byte enables; bit i covers byte i.
addr_a  in  ADDR_W  port A address.
data_a  in  DATA_W  port A write data.
q_a  out  DATA_W  port A read data.
en_b, we_b, be_b, addr_b, data_b, q_b  same as port A, for port B.
busy  out  1  clear sweep in progress; both ports are ignored.
collision  out  1  one-cycle pulse when both ports write the same address.

Behaviour:
- Reset (rst_n low, asynchronous):
  - q_a, q_b, the pipeline registers and collision go to 0.
  - The FSM enters CLEAR if CLEAR_ON_RST=1, otherwise READY.
  - busy = CLEAR_ON_RST while reset is held.
  - Array contents are not reset directly.
- FSM states: CLEAR and READY.
  - CLEAR: an internal counter writes all-zero to address cnt each cycle, counting 0 to DEPTH-1. On cnt = DEPTH-1 the FSM moves to READY; busy drops the cycle after the last write. The sweep takes exactly DEPTH cycles from the first clock after reset release.
  - READY: normal operation; the FSM never leaves READY except through reset.
- Reset asserted mid-sweep: the counter returns to 0 and the sweep restarts in full after release.
- While busy: en_a and en_b are ignored, q_a and q_b hold 0, and no user write takes effect.
- Write: if en_x & we_x, byte i of mem[addr_x] is updated from data_x only where be_x[i]=1. we_x with be_x = 0 leaves memory unchanged.
- Read: if en_x, q_x is updated.
  - OUT_REG=0: q_x is valid at the rising edge after address capture (latency 1).
  - OUT_REG=1: one extra register, so latency 2.
- en_x = 0: q_x holds its last value, and the pipeline stage holds too.
- Same-port read-during-write:
  - RDW_MODE=0: q_x returns the pre-write word.
  - RDW_MODE=1: q_x returns the merged word, with enabled bytes new and the rest old.
- Cross-port, port A writes address X while port B reads X in the same cycle: q_b returns the old word in both modes. The same rule applies with the ports swapped.
- Both ports write the same address in the same cycle:
  - Port A wins only on bytes where be_a=1; bytes written only by port B take B's data.
  - collision pulses high for one cycle, registered, the cycle after.
  - Each port's own read data follows RDW_MODE using its own write data.
- Different addresses: the two ports are fully independent, with no interaction.
- Addresses cover the full 2**ADDR_W range; there is no out-of-range case.

Decomposition:
- Package tdpram_pkg:
  - FSM state enum (ST_CLEAR, ST_READY).
  - Function merge_bytes(old, new, be) implementing the byte-lane merge.
  - Localparam helper for NBYTES = DATA_W/8.
- One sub-module, tdpram_port_rd: per-port read path. It covers RDW mux select, en hold, optional OUT_REG stage, and the busy gate. It is instantiated twice.
- The array, write arbitration, clear FSM and collision detect stay in the top.

Test Plan:
- Reset release with ADDR_W=6, CLEAR_ON_RST=1 -> busy high for exactly 64 cycles, then low. Reading addresses 0, 31 and 63 on both ports returns 8'h00.
- Port A writes 8'hAA to address 0; the next cycle port B reads address 0 -> q_b = 8'hAA one cycle later with OUT_REG=0, two cycles later with OUT_REG=1.
- DATA_W=16: write 16'h1234 full; then write 16'hABCD with be=2'b10 -> a read returns 16'hAB34.
- Same-port read-during-write: mem[5] = 8'h11, write 8'h22 to address 5 with a read -> q = 8'h11 when RDW_MODE=0, 8'h22 when RDW_MODE=1. A simultaneous port B read of address 5 returns 8'h11 in both modes.
- Both ports write address 3 in the same cycle, A = 8'hCC and B = 8'hDD with full be -> mem[3] = 8'hCC and collision pulses for exactly 1 cycle. With be_a=0 on a 16-bit variant, B's bytes land.
- Pulse rst_n low at sweep count 20 -> outputs zero immediately; busy then stays high for a full 64 cycles after release; all words read back 0.
